screen_fetch_pipe: RTL

- Pipelined framebuffer pixel fetcher for the VGA display path.
- Takes the raster pixel coordinate stream and issues word reads to a synchronous (1-cycle latency) screen RAM.
- Unpacks a BPP-bit colour index from each word and delivers a 12-bit RGB colour at fixed latency.
- Generalises the combinational fetcher:
  - parametrised bits-per-pixel and window geometry;
  - multiplier-free row addressing;
  - a page-flip base address latched once per frame;
  - read suppression within a word;
  - a border colour outside the window.

---
 rtl/screen_fetch_pipe_pkg.sv | 20 ++
 rtl/screen_fetch_pipe_if.sv | 14 +
 rtl/screen_fetch_pipe_palette.sv | 24 ++
 rtl/screen_fetch_pipe.sv | 124 ++++++++++++
 4 files changed

// File: rtl/screen_fetch_pipe_pkg.sv
// Shared display constants for the screen fetch path: RGB444 colour type,
// VGA geometry and the base 16-entry colour table.
package screen_fetch_pipe_pkg;

   localparam int unsigned RGB_W    = 12;
   localparam int unsigned VGA_H    = 640;
   localparam int unsigned VGA_V    = 480;

   typedef logic [RGB_W-1:0] rgb_t;

   localparam rgb_t PALETTE16 [16] = '{
      12'h000, 12'h00A, 12'h0A0, 12'h0AA, 12'hA00, 12'hA0A, 12'hA50, 12'hAAA,
      12'h555, 12'h55F, 12'h5F5, 12'h5FF, 12'hF55, 12'hF5F, 12'hFF5, 12'hFFF
   };

   function automatic bit bpp_legal(input int unsigned bpp);
      return (bpp == 1) || (bpp == 2) || (bpp == 4) || (bpp == 8);
   endfunction

endpackage

// File: rtl/screen_fetch_pipe_if.sv
// Screen RAM read port: strobe and word address out, read data back one cycle later.
interface screen_fetch_pipe_if #(
   parameter int unsigned ADDR_WIDTH = 16,
   parameter int unsigned DATA_WIDTH = 32
);

   logic                  ram_en;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_data;

   modport master (output ram_en, output ram_addr, input ram_data);
   modport slave  (input ram_en, input ram_addr, output ram_data);

endinterface

// File: rtl/screen_fetch_pipe_palette.sv
// Combinational colour-index to RGB444 lookup; table for narrow indices, RGB332
// expansion for 8-bit indices.
module pixel_palette
   import screen_fetch_pipe_pkg::*;
#(
   parameter int unsigned BPP = 4
) (
   input  logic [BPP-1:0] idx,
   output rgb_t           rgb
);

   if (BPP == 8) begin : g_rgb332
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
      assign {r, g, b} = idx;
      assign rgb = {r, r[2], g, g[2], b, b};
   end else begin : g_table
      logic [3:0] idx4;
      assign idx4 = 4'(idx);
      assign rgb  = PALETTE16[idx4];
   end

endmodule

// File: rtl/screen_fetch_pipe.sv
// Three-stage framebuffer pixel fetcher: address/read issue, RAM data return,
// pixel unpack and palette lookup.
module screen_fetch_pipe
   import screen_fetch_pipe_pkg::*;
#(
   parameter int unsigned SCREEN_WIDTH = 11,
   parameter int unsigned ADDR_WIDTH   = 16,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned BPP          = 4,
   parameter int unsigned WIN_X        = 76,
   parameter int unsigned WIN_Y        = 100,
   parameter int unsigned WIN_W        = 488,
   parameter int unsigned WIN_H        = 280,
   parameter rgb_t        BORDER_COLOR = 12'h000
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    px_valid,
   input  logic [SCREEN_WIDTH-1:0] x,
   input  logic [SCREEN_WIDTH-1:0] y,
   input  logic [ADDR_WIDTH-1:0]   fb_base,
   screen_fetch_pipe_if.master     ram,
   output logic                    color_valid,
   output rgb_t                    color
);

   localparam int unsigned PPW   = DATA_WIDTH / BPP;
   localparam int unsigned WPL   = WIN_W / PPW;
   localparam int unsigned SHIFT = $clog2(PPW);

   logic [SCREEN_WIDTH-1:0] xr;
   logic [SHIFT-1:0]        off0;
   logic                    in_win;
   logic                    line_start;
   logic                    frame_start;
   logic                    rd_req;
   logic [ADDR_WIDTH-1:0]   base_eff;
   logic [ADDR_WIDTH-1:0]   row_base_d;
   logic [ADDR_WIDTH-1:0]   row_base_q;
   logic [ADDR_WIDTH-1:0]   base_latched_q;

   logic                    v1_q, w1_q;
   logic [SHIFT-1:0]        off1_q;
   logic                    v2_q, w2_q, en2_q;
   logic [SHIFT-1:0]        off2_q;
   logic [DATA_WIDTH-1:0]   word_q;
   logic [DATA_WIDTH-1:0]   word_cur;
   logic [DATA_WIDTH-1:0]   word_shift;
   logic [BPP-1:0]          idx;
   rgb_t                    pal_rgb;

   assign xr     = x - SCREEN_WIDTH'(WIN_X);
   assign off0   = xr[SHIFT-1:0];
   assign in_win = (32'(x) >= WIN_X) && (32'(x) < WIN_X + WIN_W) &&
                   (32'(y) >= WIN_Y) && (32'(y) < WIN_Y + WIN_H);
   assign rd_req = px_valid && in_win && ((off0 == '0) || (32'(x) == WIN_X));

   assign line_start  = px_valid && (x == '0);
   assign frame_start = line_start && (y == '0);
   // First window row may coincide with the frame-start pixel, so bypass fb_base.
   assign base_eff    = frame_start ? fb_base : base_latched_q;

   always_comb begin
      row_base_d = row_base_q;
      if (line_start) begin
         if (32'(y) == WIN_Y) begin
            row_base_d = base_eff;
         end else if ((32'(y) > WIN_Y) && (32'(y) < WIN_Y + WIN_H)) begin
            row_base_d = row_base_q + ADDR_WIDTH'(WPL);
         end
      end
   end

   // Data for a read issued last cycle is on ram_data now; otherwise reuse the held word.
   assign word_cur   = en2_q ? ram.ram_data : word_q;
   assign word_shift = word_cur >> (32'(off2_q) * BPP);
   assign idx        = word_shift[BPP-1:0];

   pixel_palette #(
      .BPP (BPP)
   ) u_palette (
      .idx (idx),
      .rgb (pal_rgb)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         base_latched_q <= '0;
         row_base_q     <= '0;
         ram.ram_en     <= 1'b0;
         ram.ram_addr   <= '0;
         v1_q           <= 1'b0;
         w1_q           <= 1'b0;
         off1_q         <= '0;
         v2_q           <= 1'b0;
         w2_q           <= 1'b0;
         en2_q          <= 1'b0;
         off2_q         <= '0;
         word_q         <= '0;
         color_valid    <= 1'b0;
         color          <= '0;
      end else begin
         if (frame_start) begin
            base_latched_q <= fb_base;
         end
         row_base_q <= row_base_d;
         ram.ram_en <= rd_req;
         if (rd_req) begin
            ram.ram_addr <= row_base_d + ADDR_WIDTH'(xr >> SHIFT);
         end
         v1_q        <= px_valid;
         w1_q        <= px_valid && in_win;
         off1_q      <= off0;
         v2_q        <= v1_q;
         w2_q        <= w1_q;
         en2_q       <= ram.ram_en;
         off2_q      <= off1_q;
         word_q      <= word_cur;
         color_valid <= v2_q;
         color       <= w2_q ? pal_rgb : BORDER_COLOR;
      end
   end

endmodule
